// File: rtl/tv80_pfx_pkg.sv
// rtl/tv80_pfx_pkg.sv - shared types, prefix bytes and index-prefix decode for the prefix sequencer
package tv80_pfx_pkg;

  typedef enum logic [2:0] {S_IDLE, S_IDX, S_ED, S_CB, S_XCB_D, S_XCB_OP} state_e;
  typedef enum logic [1:0] {GRP_BASE = 2'b00, GRP_CB = 2'b01, GRP_ED = 2'b10} group_e;
  typedef enum logic [1:0] {IDX_HL = 2'b00, IDX_IX = 2'b01, IDX_IY = 2'b10} idx_e;

  localparam logic [7:0] PFX_DD = 8'hDD;
  localparam logic [7:0] PFX_FD = 8'hFD;
  localparam logic [7:0] PFX_ED = 8'hED;
  localparam logic [7:0] PFX_CB = 8'hCB;

  typedef struct packed {
    logic [7:0] opcode;
    group_e     group;
    idx_e       idx;
    logic [7:0] disp;
    logic       has_disp;
    logic       undoc;
    logic       illegal;
  } desc_t;

  // [1]: a DD/FD prefix changes this base opcode; [0]: an (IX/IY+d) displacement byte follows
  function automatic logic [1:0] idx_effective(input logic [7:0] op);
    logic hl_mem, hl_reg, listed;
    hl_mem = 1'b0;
    hl_reg = 1'b0;
    case (op[7:6])
      2'b00: begin
        hl_mem = (op[5:3] == 3'd6) && (op[2:0] inside {3'd4, 3'd5, 3'd6});
        hl_reg = (op[5:4] == 2'b10) && (op[2:0] inside {3'd4, 3'd5, 3'd6});
      end
      2'b01: begin
        if (op != 8'h76) begin
          hl_mem = (op[5:3] == 3'd6) || (op[2:0] == 3'd6);
          hl_reg = (op[5:4] == 2'b10) || (op[2:1] == 2'b10);
        end
      end
      2'b10: begin
        hl_mem = (op[2:0] == 3'd6);
        hl_reg = (op[2:1] == 2'b10);
      end
      default: ;
    endcase
    listed = op inside {8'h21, 8'h22, 8'h2A, 8'h23, 8'h2B, 8'h09, 8'h19, 8'h29, 8'h39,
                        8'hE1, 8'hE3, 8'hE5, 8'hE9, 8'hF9};
    return {hl_mem | hl_reg | listed, hl_mem};
  endfunction

endpackage

// File: rtl/tv80_pfx_outreg.sv
// rtl/tv80_pfx_outreg.sv - one-slot valid/ready descriptor register, reloadable in the cycle it is taken
module tv80_pfx_outreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tv80_prefix_seq.sv
// rtl/tv80_prefix_seq.sv - TV80 DD/FD/ED/CB prefix-chain sequencer producing one descriptor per instruction
module tv80_prefix_seq
  import tv80_pfx_pkg::*;
#(
  parameter int CNT_W     = 3,
  parameter int UNDOC_EN  = 1,
  parameter int INT_CHAIN = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_opcode,
  output logic [1:0]       out_group,
  output logic [1:0]       out_idx,
  output logic [7:0]       out_disp,
  output logic             out_has_disp,
  output logic             out_undoc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] out_pfx_cnt,
  output logic             m1_pulse,
  output logic             int_window
);

  localparam int DW = $bits(desc_t) + CNT_W;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e           state;
  idx_e             idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             disp_pend_q, bad_q, m1_q;
  logic [7:0]       op_q, disp_q;

  logic             accept, is_pfx, ld, bad;
  logic [1:0]       eff;
  desc_t            nd, sq;
  logic [DW-1:0]    slot_q;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_pfx   = in_byte inside {PFX_DD, PFX_FD, PFX_ED, PFX_CB};
  assign eff      = idx_effective(in_byte);

  // Descriptor assembly for the byte that completes an instruction
  always_comb begin
    ld        = 1'b0;
    bad       = 1'b0;
    nd        = '0;
    nd.opcode = in_byte;
    if (accept) begin
      case (state)
        S_IDLE, S_IDX: begin
          if (disp_pend_q) begin
            ld          = 1'b1;
            nd.opcode   = op_q;
            nd.idx      = idx_q;
            nd.disp     = in_byte;
            nd.has_disp = 1'b1;
          end else if (!is_pfx) begin
            ld = 1'b1;
            if (state == S_IDX) begin
              if (!eff[1])     bad    = 1'b1;
              else if (eff[0]) ld     = 1'b0;
              else             nd.idx = idx_q;
            end
          end
        end
        S_ED: begin
          ld       = 1'b1;
          nd.group = GRP_ED;
          bad      = bad_q;
        end
        S_CB: begin
          ld       = 1'b1;
          nd.group = GRP_CB;
        end
        S_XCB_OP: begin
          ld          = 1'b1;
          nd.group    = GRP_CB;
          nd.idx      = idx_q;
          nd.disp     = disp_q;
          nd.has_disp = 1'b1;
        end
        default: ;
      endcase
    end
    nd.undoc   = bad && (UNDOC_EN != 0);
    nd.illegal = bad && (UNDOC_EN == 0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      idx_q       <= IDX_HL;
      cnt_q       <= '0;
      disp_pend_q <= 1'b0;
      bad_q       <= 1'b0;
      m1_q        <= 1'b0;
      op_q        <= '0;
      disp_q      <= '0;
    end else begin
      // XCB displacement/opcode and (IX+d) displacement are operand reads, not M1
      m1_q <= accept && ((state inside {S_IDLE, S_ED, S_CB}) || (state == S_IDX && !disp_pend_q));
      if (flush || (accept && ld)) begin
        state       <= S_IDLE;
        idx_q       <= IDX_HL;
        cnt_q       <= '0;
        disp_pend_q <= 1'b0;
        bad_q       <= 1'b0;
      end else if (accept) begin
        case (state)
          S_IDLE, S_IDX: begin
            if (in_byte == PFX_DD || in_byte == PFX_FD) begin
              state <= S_IDX;
              if (in_byte == PFX_DD) idx_q <= IDX_IX;
              else                   idx_q <= IDX_IY;
              if (cnt_q != '1) cnt_q <= cnt_q + CNT_ONE;
            end else if (in_byte == PFX_ED) begin
              state <= S_ED;
              idx_q <= IDX_HL;
              bad_q <= (state == S_IDX);
            end else if (in_byte == PFX_CB) begin
              if (state == S_IDX) state <= S_XCB_D;
              else                state <= S_CB;
            end else begin
              disp_pend_q <= 1'b1;
              op_q        <= in_byte;
            end
          end
          S_XCB_D: begin
            disp_q <= in_byte;
            state  <= S_XCB_OP;
          end
          default: ;
        endcase
      end
    end
  end

  tv80_pfx_outreg #(.W(DW)) u_outreg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (accept && ld),
    .load_data ({nd, cnt_q}),
    .ready     (out_ready),
    .valid     (out_valid),
    .data      (slot_q)
  );

  assign sq           = desc_t'(slot_q[DW-1:CNT_W]);
  assign out_pfx_cnt  = slot_q[CNT_W-1:0];
  assign out_opcode   = sq.opcode;
  assign out_group    = sq.group;
  assign out_idx      = sq.idx;
  assign out_disp     = sq.disp;
  assign out_has_disp = sq.has_disp;
  assign out_undoc    = sq.undoc;
  assign out_illegal  = sq.illegal;
  assign m1_pulse     = m1_q;
  assign int_window   = (state == S_IDLE) || ((INT_CHAIN != 0) && (state == S_IDX) && !disp_pend_q);

endmodule

// File: tb/tb_tv80_prefix_seq.sv
// tb/tb_tv80_prefix_seq.sv - table-driven and sequence checks of tv80_prefix_seq (UNDOC_EN 1 and 0)
module tb_tv80_prefix_seq;

  typedef struct {
    logic [79:0] bytes;
    int          n;
    logic [7:0]  op;
    logic [1:0]  grp;
    logic [1:0]  idx;
    logic [7:0]  disp;
    logic        hd;
    logic        undoc;
    logic [2:0]  cnt;
    int          m1;
  } vec_t;

  typedef struct {
    logic [7:0] op;
    logic [1:0] grp;
    logic [1:0] idx;
    logic [7:0] disp;
    logic       hd;
    logic       undoc;
    logic       ill;
    logic [2:0] cnt;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset_n, in_valid, flush, out_ready;
  logic [7:0] in_byte;

  logic       in_ready, out_valid, out_has_disp, out_undoc, out_illegal, m1_pulse, int_window;
  logic [7:0] out_opcode, out_disp;
  logic [1:0] out_group, out_idx;
  logic [2:0] out_pfx_cnt;

  logic       in_ready2, out_valid2, out_has_disp2, out_undoc2, out_illegal2, m1_pulse2, int_window2;
  logic [7:0] out_opcode2, out_disp2;
  logic [1:0] out_group2, out_idx2;
  logic [2:0] out_pfx_cnt2;

  int   n_vec = 0, n_bad = 0;
  int   m1_total = 0;
  rec_t c1 [256];
  rec_t c2 [256];
  int   w1 = 0, w2 = 0, r1 = 0, r2 = 0;
  vec_t vt [13];

  always #5 clk = ~clk;

  tv80_prefix_seq #(.CNT_W(3), .UNDOC_EN(1), .INT_CHAIN(0)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_group(out_group), .out_idx(out_idx), .out_disp(out_disp), .out_has_disp(out_has_disp),
    .out_undoc(out_undoc), .out_illegal(out_illegal), .out_pfx_cnt(out_pfx_cnt),
    .m1_pulse(m1_pulse), .int_window(int_window)
  );

  tv80_prefix_seq #(.CNT_W(3), .UNDOC_EN(0), .INT_CHAIN(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2), .in_byte(in_byte),
    .flush(flush), .out_valid(out_valid2), .out_ready(out_ready), .out_opcode(out_opcode2),
    .out_group(out_group2), .out_idx(out_idx2), .out_disp(out_disp2), .out_has_disp(out_has_disp2),
    .out_undoc(out_undoc2), .out_illegal(out_illegal2), .out_pfx_cnt(out_pfx_cnt2),
    .m1_pulse(m1_pulse2), .int_window(int_window2)
  );

  always @(negedge clk) begin
    if (reset_n) begin
      if (m1_pulse) m1_total++;
      if (out_valid && out_ready) begin
        c1[w1 % 256] = '{out_opcode, out_group, out_idx, out_disp, out_has_disp,
                         out_undoc, out_illegal, out_pfx_cnt};
        w1++;
      end
      if (out_valid2 && out_ready) begin
        c2[w2 % 256] = '{out_opcode2, out_group2, out_idx2, out_disp2, out_has_disp2,
                         out_undoc2, out_illegal2, out_pfx_cnt2};
        w2++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_rec(input string nm, input rec_t r, input vec_t v, input bit strict);
    chk({nm, ".op"},  r.op,  v.op);
    chk({nm, ".grp"}, r.grp, v.grp);
    chk({nm, ".idx"}, r.idx, v.idx);
    chk({nm, ".hd"},  r.hd,  v.hd);
    if (v.hd) chk({nm, ".disp"}, r.disp, v.disp);
    chk({nm, ".cnt"}, r.cnt, v.cnt);
    chk({nm, ".undoc"},   r.undoc, strict ? 1'b0 : v.undoc);
    chk({nm, ".illegal"}, r.ill,   strict ? v.undoc : 1'b0);
  endtask

  task automatic take_desc(input string nm, input vec_t v);
    if (r1 >= w1) chk({nm, ".present"}, 32'd0, 32'd1);
    else begin
      check_rec(nm, c1[r1 % 256], v, 1'b0);
      r1++;
    end
    if (r2 >= w2) chk({nm, ".present2"}, 32'd0, 32'd1);
    else begin
      check_rec({nm, "/u0"}, c2[r2 % 256], v, 1'b1);
      r2++;
    end
  endtask

  function automatic vec_t mkv(input logic [7:0] op, input logic [1:0] grp, input logic [1:0] idx,
                               input logic [7:0] disp, input logic hd, input logic undoc,
                               input logic [2:0] cnt);
    vec_t v;
    v = '{80'h0, 0, op, grp, idx, disp, hd, undoc, cnt, 0};
    return v;
  endfunction

  initial begin
    logic [79:0] t;
    int          m1_start;

    vt[0]  = '{80'hDD04,               2, 8'h04, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1, 3'd1, 2};
    vt[1]  = '{80'hDD3405,             3, 8'h34, 2'd0, 2'd1, 8'h05, 1'b1, 1'b0, 3'd1, 2};
    vt[2]  = '{80'hFDCBF006,           4, 8'h06, 2'd1, 2'd2, 8'hF0, 1'b1, 1'b0, 3'd1, 2};
    vt[3]  = '{80'hDDFDDD21,           4, 8'h21, 2'd0, 2'd1, 8'h00, 1'b0, 1'b0, 3'd3, 4};
    vt[4]  = '{80'h04,                 1, 8'h04, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd0, 1};
    vt[5]  = '{80'hED44,               2, 8'h44, 2'd2, 2'd0, 8'h00, 1'b0, 1'b0, 3'd0, 2};
    vt[6]  = '{80'hCB07,               2, 8'h07, 2'd1, 2'd0, 8'h00, 1'b0, 1'b0, 3'd0, 2};
    vt[7]  = '{80'hDDED44,             3, 8'h44, 2'd2, 2'd0, 8'h00, 1'b0, 1'b1, 3'd1, 3};
    vt[8]  = '{80'hFD65,               2, 8'h65, 2'd0, 2'd2, 8'h00, 1'b0, 1'b0, 3'd1, 2};
    vt[9]  = '{80'hDD76,               2, 8'h76, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1, 3'd1, 2};
    vt[10] = '{80'hDD86FE,             3, 8'h86, 2'd0, 2'd1, 8'hFE, 1'b1, 1'b0, 3'd1, 2};
    vt[11] = '{80'hDDDDDDDDDDDDDDDD21, 9, 8'h21, 2'd0, 2'd1, 8'h00, 1'b0, 1'b0, 3'd7, 9};
    vt[12] = '{80'hFDE9,               2, 8'hE9, 2'd0, 2'd2, 8'h00, 1'b0, 1'b0, 3'd1, 2};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    flush     = 1'b0;
    out_ready = 1'b1;
    idle(3);
    reset_n = 1'b1;
    #1;

    chk("rst.out_valid",  out_valid,   0);
    chk("rst.in_ready",   in_ready,    1);
    chk("rst.int_window", int_window,  1);
    chk("rst.m1_pulse",   m1_pulse,    0);
    chk("rst.pfx_cnt",    out_pfx_cnt, 0);
    chk("rst.opcode",     out_opcode,  0);
    chk("rst.in_ready2",   in_ready2,   1);
    chk("rst.int_window2", int_window2, 1);
    chk("rst.m1_pulse2",   m1_pulse2,   0);

    for (int i = 0; i < 13; i++) begin
      m1_start = m1_total;
      for (int j = 0; j < vt[i].n; j++) begin
        t = vt[i].bytes >> (8 * (vt[i].n - 1 - j));
        push(t[7:0]);
      end
      idle(3);
      chk($sformatf("v%0d.m1", i), m1_total - m1_start, vt[i].m1);
      take_desc($sformatf("v%0d", i), vt[i]);
    end

    push(8'hDD);
    chk("chain.int_window_dd", int_window, 0);
    push(8'hFD);
    push(8'hDD);
    chk("chain.int_window_ddd", int_window, 0);
    push(8'h21);
    chk("chain.out_valid", out_valid, 1);
    chk("chain.int_window_emit", int_window, 1);
    idle(2);
    take_desc("chain", mkv(8'h21, 2'd0, 2'd1, 8'h00, 1'b0, 1'b0, 3'd3));

    out_ready = 1'b0;
    push(8'h04);
    chk("bp.in_ready_low", in_ready, 0);
    fork
      push(8'h0C);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(3);
    take_desc("bp.first",  mkv(8'h04, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd0));
    take_desc("bp.second", mkv(8'h0C, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd0));

    push(8'hDD);
    push(8'hCB);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    chk("rstmid.out_valid",  out_valid,   0);
    chk("rstmid.int_window", int_window,  1);
    chk("rstmid.pfx_cnt",    out_pfx_cnt, 0);
    push(8'h04);
    idle(2);
    take_desc("rstmid.inc_b", mkv(8'h04, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd0));

    push(8'hDD);
    flush = 1'b1;
    #1;
    chk("flush.in_ready", in_ready, 0);
    idle(1);
    flush = 1'b0;
    chk("flush.int_window", int_window, 1);
    push(8'h23);
    idle(2);
    take_desc("flush.inc_hl", mkv(8'h23, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd0));

    chk("extra_desc", w1 - r1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
